// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) doubling, round counts and FSM state type.
package aes_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Byte x of the S-box sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when inLast), AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] inState,
    input  logic [BLK_W-1:0] inKey,
    input  logic             inLast,
    output logic [BLK_W-1:0] outState
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte b of the block is [127-8b -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        sb       = '{default: '0};
        sr       = '{default: '0};
        mc       = '{default: '0};
        outState = '0;
        for (int b = 0; b < 16; b++) begin
            sb[b] = sbox(inState[127-8*b -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = gf_mul2(sr[4*c]) ^ gf_mul2(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ gf_mul2(sr[4*c+1]) ^ gf_mul2(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul2(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = gf_mul2(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
        end
        for (int b = 0; b < 16; b++) begin
            outState[127-8*b -: 8] = (inLast ? sr[b] : mc[b]) ^ inKey[127-8*b -: 8];
        end
    end

endmodule

// File: rtl/aes_block_enc_param.sv
// Iterative AES-128/256 encryptor, 1 or 2 rounds per clock, keys fetched by index from an external
// store. Optional XTS-style tweak whitening when AES_BLK_TWEAK_EN is defined.
module aes_block_enc_param
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS         = 256,
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic                                inClk,
    input  logic                                inRst,
    input  logic                                inValid,
    output logic                                outReady,
    input  logic [BLK_W-1:0]                    inData,
`ifdef AES_BLK_TWEAK_EN
    input  logic [BLK_W-1:0]                    inTweak,
`endif
    output logic [3:0]                          outKeyIdx,
    input  logic [BLK_W*ROUNDS_PER_CYCLE-1:0]   inRoundKey,
    output logic                                outValid,
    input  logic                                inReady,
    output logic [BLK_W-1:0]                    outData,
    output logic                                outBusy
);

    localparam int unsigned NR  = (KEY_BITS == 128) ? NR_128 : NR_256;
    localparam int unsigned RPC = ROUNDS_PER_CYCLE;

    if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_block_enc_param: KEY_BITS must be 128 or 256");
    end
    if (!(RPC == 1 || RPC == 2)) begin : g_bad_rpc
        $error("aes_block_enc_param: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    state_t                  state_q, state_d;
    logic [3:0]              ctr_q, ctr_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic [BLK_W-1:0]        data_q, data_d;
    logic                    valid_q, valid_d;
    logic [BLK_W-1:0]        load_mask;
    logic [BLK_W-1:0]        out_mask;
    logic [RPC:0][BLK_W-1:0] chain;
    logic                    last_step;
    logic                    accept;

`ifdef AES_BLK_TWEAK_EN
    logic [BLK_W-1:0] tweak_q;

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            tweak_q <= '0;
        end else if (accept) begin
            tweak_q <= inTweak;
        end
    end

    assign load_mask = inTweak;
    assign out_mask  = tweak_q;
`else
    assign load_mask = '0;
    assign out_mask  = '0;
`endif

    assign chain[0] = blk_q;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic last;
        assign last = (5'(ctr_q) + 5'(j)) == 5'(NR);

        aes_round_comb u_round (
            .inState  (chain[j]),
            .inKey    (inRoundKey[BLK_W*j +: BLK_W]),
            .inLast   (last),
            .outState (chain[j+1])
        );
    end

    // This edge applies round NR when the highest key used this cycle is key NR.
    assign last_step = (5'(ctr_q) + 5'(RPC - 1)) == 5'(NR);

    assign outReady  = (state_q == IDLE) || ((state_q == DONE) && inReady);
    assign accept    = inValid && outReady;
    assign outKeyIdx = (state_q == RUN) ? ctr_q : 4'd0;
    assign outBusy   = (state_q != IDLE);
    assign outValid  = valid_q;
    assign outData   = data_q;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        blk_d   = blk_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    blk_d   = inData ^ load_mask ^ inRoundKey[BLK_W-1:0];
                    ctr_d   = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d = chain[RPC];
                ctr_d = ctr_q + 4'(RPC);
                if (last_step) begin
                    data_d  = chain[RPC] ^ out_mask;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (inReady) begin
                    valid_d = 1'b0;
                    if (accept) begin
                        blk_d   = inData ^ load_mask ^ inRoundKey[BLK_W-1:0];
                        ctr_d   = 4'd1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state_q <= IDLE;
            ctr_q   <= 4'd0;
            blk_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_aes_block_enc_param.sv
// Bench for aes_block_enc_param: an AES-256/1-round and an AES-128/2-round instance against a
// behavioural AES model (S-box derived from GF inverses). Tweak tests under AES_BLK_TWEAK_EN.
module tb_aes_block_enc_param;

    logic         clk;
    logic         rst;
    logic         in_valid    [2];
    logic         out_ready   [2];
    logic [127:0] in_data     [2];
    logic [3:0]   out_key_idx [2];
    logic         out_valid   [2];
    logic         in_ready    [2];
    logic [127:0] out_data    [2];
    logic         out_busy    [2];
`ifdef AES_BLK_TWEAK_EN
    logic [127:0] in_tweak    [2];
`endif
    logic [127:0] round_key_a;
    logic [255:0] round_key_b;

    logic [127:0] rk_a [17];
    logic [127:0] rk_b [17];
    logic [7:0]   sbox_ref [256];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    aes_block_enc_param #(.KEY_BITS(256), .ROUNDS_PER_CYCLE(1)) u_dut_a (
        .inClk      (clk),
        .inRst      (rst),
        .inValid    (in_valid[0]),
        .outReady   (out_ready[0]),
        .inData     (in_data[0]),
`ifdef AES_BLK_TWEAK_EN
        .inTweak    (in_tweak[0]),
`endif
        .outKeyIdx  (out_key_idx[0]),
        .inRoundKey (round_key_a),
        .outValid   (out_valid[0]),
        .inReady    (in_ready[0]),
        .outData    (out_data[0]),
        .outBusy    (out_busy[0])
    );

    aes_block_enc_param #(.KEY_BITS(128), .ROUNDS_PER_CYCLE(2)) u_dut_b (
        .inClk      (clk),
        .inRst      (rst),
        .inValid    (in_valid[1]),
        .outReady   (out_ready[1]),
        .inData     (in_data[1]),
`ifdef AES_BLK_TWEAK_EN
        .inTweak    (in_tweak[1]),
`endif
        .outKeyIdx  (out_key_idx[1]),
        .inRoundKey (round_key_b),
        .outValid   (out_valid[1]),
        .inReady    (in_ready[1]),
        .outData    (out_data[1]),
        .outBusy    (out_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key store: combinational lookup by the engine's requested index.
    always_comb begin
        round_key_a = rk_a[out_key_idx[0]];
        round_key_b = {rk_b[int'(out_key_idx[1]) + 1], rk_b[out_key_idx[1]]};
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            s = inv;
            v = inv;
            for (int k = 0; k < 4; k++) begin
                v = {v[6:0], v[7]};
                s = s ^ v;
            end
            sbox_ref[x] = s ^ 8'h63;
        end
    endtask

    // d=0: AES-256 store, d=1: AES-128 store (key taken from the upper 128 bits).
    task automatic expand(input int d, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        int nr;
        nk   = (d == 0) ? 8 : 4;
        nr   = (d == 0) ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (d == 0) rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else        rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] aes_ref(input int d, input logic [127:0] blk);
        logic [7:0]   st  [4][4];
        logic [7:0]   tmp [4][4];
        logic [127:0] k;
        logic [127:0] res;
        int nr;
        nr = (d == 0) ? 14 : 10;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = blk[127-8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= nr; rnd++) begin
            if (rnd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) tmp[r][c] = sbox_ref[st[r][(c+r)%4]];
                for (int c = 0; c < 4; c++) begin
                    if (rnd < nr) begin
                        for (int r = 0; r < 4; r++)
                            st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c])
                                       ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
                    end else begin
                        for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
                    end
                end
            end
            k = (d == 0) ? rk_a[rnd] : rk_b[rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ k[127-8*(4*c+r) -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = st[r][c];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, " ready"},  128'(out_ready[d]),   128'd1);
        check({tag, " valid"},  128'(out_valid[d]),   128'd0);
        check({tag, " busy"},   128'(out_busy[d]),    128'd0);
        check({tag, " data"},   out_data[d],          128'd0);
        check({tag, " keyidx"}, 128'(out_key_idx[d]), 128'd0);
    endtask

    task automatic accept_blk(input int d, input logic [127:0] pt, input string tag);
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = pt;
        #1 check({tag, " ready_before"}, 128'(out_ready[d]), 128'd1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = rnd128();
        check({tag, " busy_run"},   128'(out_busy[d]),    128'd1);
        check({tag, " ready_run"},  128'(out_ready[d]),   128'd0);
        check({tag, " keyidx_run"}, 128'(out_key_idx[d]), 128'd1);
    endtask

    task automatic wait_result(input int d, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        while (!out_valid[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), (d == 0) ? 128'd14 : 128'd5);
        check({tag, " data"}, out_data[d], exp);
    endtask

    task automatic take(input int d, input string tag);
        in_ready[d] = 1'b1;
        #1 check({tag, " ready_take"}, 128'(out_ready[d]), 128'd1);
        @(negedge clk);
        in_ready[d] = 1'b0;
        check({tag, " valid_after"}, 128'(out_valid[d]), 128'd0);
        check({tag, " busy_after"},  128'(out_busy[d]),  128'd0);
    endtask

    task automatic run_block(input int d, input logic [127:0] pt, input logic [127:0] tw,
                             input string tag, output logic [127:0] got);
        logic [127:0] exp;
        exp = aes_ref(d, pt ^ tw) ^ tw;
`ifdef AES_BLK_TWEAK_EN
        in_tweak[d] = tw;
`endif
        accept_blk(d, pt, tag);
        wait_result(d, exp, tag);
        got = out_data[d];
        take(d, tag);
    endtask

    task automatic back_to_back(input int d, input string tag);
        logic [127:0] p [4];
        logic [127:0] e [4];
        int  cyc;
        int  ni;
        int  no;
        int  last;
        int  gap;
        logic acc;
        gap = (d == 0) ? 15 : 6;
        for (int i = 0; i < 4; i++) begin
            p[i] = rnd128();
            e[i] = aes_ref(d, p[i]);
        end
        cyc  = 0;
        ni   = 0;
        no   = 0;
        last = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = p[0];
        in_ready[d] = 1'b1;
        while (no < 4 && cyc < 200) begin
            #1;
            acc = out_ready[d] && in_valid[d];
            if (out_valid[d]) begin
                check({tag, " data"}, out_data[d], e[no]);
                if (no > 0) check({tag, " gap"}, 128'(cyc - last), 128'(gap));
                if (ni < 4) check({tag, " accept_on_take"}, 128'(out_ready[d]), 128'd1);
                last = cyc;
                no++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                ni++;
                if (ni < 4) in_data[d] = p[ni];
                else        in_valid[d] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " outputs_seen"}, 128'(no), 128'd4);
        in_valid[d] = 1'b0;
        in_ready[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] pt;
        logic [127:0] pt2;
        logic [127:0] exp1;
        logic [127:0] exp2;
        logic [255:0] key256;
        logic [255:0] key128;

        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        pt     = 128'h00112233445566778899aabbccddeeff;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = '0;
            in_ready[d] = 1'b0;
`ifdef AES_BLK_TWEAK_EN
            in_tweak[d] = '0;
`endif
        end
        for (int i = 0; i < 17; i++) begin
            rk_a[i] = '0;
            rk_b[i] = '0;
        end
        build_sbox();
        expand(0, key256);
        expand(1, key128);

        repeat (2) @(negedge clk);
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        rst = 1'b0;

        // Known-answer vectors.
        run_block(0, pt, '0, "t1", got);
        check("t1 vector", got, 128'h8ea2b7ca516745bfeafc49904b496089);
        run_block(1, pt, '0, "t2", got);
        check("t2 vector", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Random keys and plaintexts.
        for (int i = 0; i < 3; i++) begin
            expand(0, {rnd128(), rnd128()});
            expand(1, {rnd128(), rnd128()});
            run_block(0, rnd128(), '0, "rand_a", got);
            run_block(1, rnd128(), '0, "rand_b", got);
        end

        // Backpressure: result held, second block waits for the take.
        pt2  = rnd128();
        exp1 = aes_ref(0, pt);
        exp2 = aes_ref(0, pt2);
        accept_blk(0, pt, "t3");
        wait_result(0, exp1, "t3 first");
        in_valid[0] = 1'b1;
        in_data[0]  = pt2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t3 hold valid", 128'(out_valid[0]), 128'd1);
            check("t3 hold data",  out_data[0],        exp1);
            check("t3 hold ready", 128'(out_ready[0]), 128'd0);
        end
        in_ready[0] = 1'b1;
        #1 check("t3 ready_on_take", 128'(out_ready[0]), 128'd1);
        @(negedge clk);
        in_ready[0] = 1'b0;
        in_valid[0] = 1'b0;
        in_data[0]  = rnd128();
        check("t3 valid_cleared", 128'(out_valid[0]),   128'd0);
        check("t3 second_busy",   128'(out_busy[0]),    128'd1);
        check("t3 second_keyidx", 128'(out_key_idx[0]), 128'd1);
        wait_result(0, exp2, "t3 second");
        take(0, "t3");

        // Back-to-back streams.
        back_to_back(0, "t4_a");
        back_to_back(1, "t4_b");

        // Reset in the middle of a block.
        accept_blk(0, rnd128(), "t5");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 check_idle(0, "t5 in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check("t5 busy_after_reset", 128'(out_busy[0]), 128'd0);
        run_block(0, rnd128(), '0, "t5 after", got);

`ifdef AES_BLK_TWEAK_EN
        expand(0, key256);
        run_block(0, pt, '0, "t6 zero", got);
        check("t6 zero vector", got, 128'h8ea2b7ca516745bfeafc49904b496089);
        run_block(0, pt, {128{1'b1}}, "t6 ones", got);
        check("t6 ones model", got, aes_ref(0, ~pt) ^ {128{1'b1}});
        run_block(0, rnd128(), rnd128(), "t6 rand_a", got);
        run_block(1, rnd128(), rnd128(), "t6 rand_b", got);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
